// File: rtl/cache_mem_arbiter.sv
// Shares one line-burst memory port between icache refills and dcache write-backs/refills.
// Define ARB_ROUND_ROBIN_EN for two-way round-robin instead of dcache priority with a starvation guard.
module cache_mem_arbiter #(
  parameter int LINE_WORDS   = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ic_rd_req,
  input  logic [31:0]              ic_addr,
  output logic                     ic_gnt,
  output logic [32*LINE_WORDS-1:0] ic_rd_data,
  input  logic                     dc_rd_req,
  input  logic                     dc_wr_req,
  input  logic [31:0]              dc_addr,
  input  logic [32*LINE_WORDS-1:0] dc_wr_data,
  output logic                     dc_gnt,
  output logic [32*LINE_WORDS-1:0] dc_rd_data,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [32*LINE_WORDS-1:0] mem_wr_data,
  input  logic                     mem_ready,
  input  logic                     mem_done,
  input  logic [32*LINE_WORDS-1:0] mem_rd_data,
  output logic                     busy
);
  localparam int          OFS_BITS  = $clog2(LINE_WORDS * 4);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFS_BITS) - 32'd1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_t;

  state_t      state_r, state_next_s;
  owner_t      owner_r, win_s;
  logic        win_valid_s;
  logic        win_we_s;
  logic [31:0] win_addr_s;
  logic        dc_any_s;
  logic        take_s;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner_r;
`else
  localparam int           CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_r;
`endif

  // Winner selection, evaluated every cycle but only acted on in IDLE
  always_comb begin
    win_valid_s = 1'b0;
    win_s       = OWN_IC;
    win_we_s    = 1'b0;
    dc_any_s    = dc_rd_req | dc_wr_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (dc_any_s && (!ic_rd_req || (last_owner_r == OWN_IC))) begin
      win_valid_s = 1'b1;
      win_s       = OWN_DC;
      win_we_s    = dc_wr_req;
    end else if (ic_rd_req) begin
      win_valid_s = 1'b1;
      win_s       = OWN_IC;
    end else begin
      win_valid_s = 1'b0;
    end
`else
    if (ic_rd_req && (starve_r == STARVE_MAX)) begin
      win_valid_s = 1'b1;
      win_s       = OWN_IC;
    end else if (dc_any_s) begin
      win_valid_s = 1'b1;
      win_s       = OWN_DC;
      win_we_s    = dc_wr_req;
    end else if (ic_rd_req) begin
      win_valid_s = 1'b1;
      win_s       = OWN_IC;
    end else begin
      win_valid_s = 1'b0;
    end
`endif
    if (win_s == OWN_DC) begin
      win_addr_s = dc_addr;
    end else begin
      win_addr_s = ic_addr;
    end
    take_s = (state_r == IDLE) && win_valid_s;
  end

  // Next-state logic for the transaction sequencer
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (win_valid_s) state_next_s = ISSUE; else state_next_s = IDLE;
      ISSUE:   if (mem_ready)   state_next_s = WAIT;  else state_next_s = ISSUE;
      WAIT:    if (mem_done)    state_next_s = RESP;  else state_next_s = WAIT;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and control outputs, registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      mem_req <= 1'b0;
      busy    <= 1'b0;
      ic_gnt  <= 1'b0;
      dc_gnt  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      mem_req <= (state_next_s == ISSUE);
      busy    <= (state_next_s != IDLE);
      ic_gnt  <= (state_next_s == RESP) && (owner_r == OWN_IC);
      dc_gnt  <= (state_next_s == RESP) && (owner_r == OWN_DC);
    end
  end

  // Latch the winning request; these registers drive the memory port directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r     <= OWN_IC;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wr_data <= {(32*LINE_WORDS){1'b0}};
    end else if (take_s) begin
      owner_r  <= win_s;
      mem_we   <= win_we_s;
      mem_addr <= win_addr_s & ADDR_MASK;
      if (win_we_s) begin
        mem_wr_data <= dc_wr_data;
      end
    end
  end

  // Capture returned read lines for the owner; writes leave both lines untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_rd_data <= {(32*LINE_WORDS){1'b0}};
      dc_rd_data <= {(32*LINE_WORDS){1'b0}};
    end else if ((state_r == WAIT) && mem_done && !mem_we) begin
      if (owner_r == OWN_DC) begin
        dc_rd_data <= mem_rd_data;
      end else begin
        ic_rd_data <= mem_rd_data;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the last owner so ties alternate between the caches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_r <= OWN_IC;
    end else if (take_s) begin
      last_owner_r <= win_s;
    end
  end
`else
  // Count dcache grants that bypassed a waiting icache; saturates at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_r <= {CW{1'b0}};
    end else if (take_s) begin
      if (win_s == OWN_IC) begin
        starve_r <= {CW{1'b0}};
      end else if (ic_rd_req && (starve_r != STARVE_MAX)) begin
        starve_r <= starve_r + CW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: vector table of single transactions plus
// hand-written sequences for starvation/round-robin, ready stall, spurious done and reset.
module tb_cache_mem_arbiter;
  localparam int LW = 32 * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_rd_req, dc_rd_req, dc_wr_req;
  logic [31:0]   ic_addr, dc_addr;
  logic [LW-1:0] dc_wr_data, mem_rd_data;
  logic          mem_ready, mem_done;
  logic          ic_gnt, dc_gnt, mem_req, mem_we, busy;
  logic [31:0]   mem_addr;
  logic [LW-1:0] ic_rd_data, dc_rd_data, mem_wr_data;

  int checks = 0;
  int errors = 0;
  logic [LW-1:0] exp_ic_line, exp_dc_line;

  cache_mem_arbiter #(.LINE_WORDS(8), .STARVE_LIMIT(16)) dut (
    .clk(clk), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rd_data(ic_rd_data),
    .dc_rd_req(dc_rd_req), .dc_wr_req(dc_wr_req), .dc_addr(dc_addr),
    .dc_wr_data(dc_wr_data), .dc_gnt(dc_gnt), .dc_rd_data(dc_rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ic;
    logic        dcr;
    logic        dcw;
    logic [31:0] ic_a;
    logic [31:0] dc_a;
    logic        exp_dc;
    logic        exp_we;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vec [6];

  function automatic logic [LW-1:0] rline(input int i);
    logic [LW-1:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'hA500_0000 + 32'(i * 16 + w);
    return r;
  endfunction

  function automatic logic [LW-1:0] wline(input int i);
    logic [LW-1:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'hD000_0000 + 32'(i * 16 + w);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " mem_req"}, mem_req, 0);
    chk({nm, " mem_we"}, mem_we, 0);
    chk({nm, " mem_addr"}, mem_addr, 0);
    chk({nm, " mem_wr_data"}, mem_wr_data, 0);
    chk({nm, " ic_gnt"}, ic_gnt, 0);
    chk({nm, " dc_gnt"}, dc_gnt, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " ic_rd_data"}, ic_rd_data, 0);
    chk({nm, " dc_rd_data"}, dc_rd_data, 0);
  endtask

  initial begin
    logic [LW-1:0] wd;
    logic          e_dc;

    vec[0] = '{1'b1, 1'b0, 1'b0, 32'h1FC0_0024, 32'h0000_0000, 1'b0, 1'b0, 32'h1FC0_0020};
    vec[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h8000_1040, 1'b1, 1'b1, 32'h8000_1040};
    vec[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h8000_1040, 1'b1, 1'b0, 32'h8000_1040};
`ifdef ARB_ROUND_ROBIN_EN
    vec[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h1234_567C, 1'b0, 1'b0, 32'h0000_0000};
    vec[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h1234_567C, 1'b1, 1'b0, 32'h1234_5660};
`else
    vec[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h1234_567C, 1'b1, 1'b0, 32'h1234_5660};
    vec[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h1234_567C, 1'b0, 1'b0, 32'h0000_0000};
`endif
    vec[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFE0};

    rst = 1'b1;
    ic_rd_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
    ic_addr = 32'd0; dc_addr = 32'd0; dc_wr_data = '0;
    mem_ready = 1'b0; mem_done = 1'b0; mem_rd_data = '0;
    exp_ic_line = '0; exp_dc_line = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Contention: dcache re-requests continuously while icache waits
    ic_rd_req = 1'b1; dc_rd_req = 1'b1;
    ic_addr = 32'h1000_0000; dc_addr = 32'h2000_0000;
    for (int g = 0; g < 34; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      e_dc = ((g % 2) == 0);
`else
      e_dc = ((g % 17) != 16);
`endif
      tick();
      chk($sformatf("starve[%0d] mem_addr", g), mem_addr, e_dc ? 32'h2000_0000 : 32'h1000_0000);
      mem_ready = 1'b1; mem_rd_data = rline(100 + g);
      tick();
      mem_ready = 1'b0; mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      if (e_dc) exp_dc_line = rline(100 + g); else exp_ic_line = rline(100 + g);
      chk($sformatf("starve[%0d] dc_gnt", g), dc_gnt, e_dc);
      chk($sformatf("starve[%0d] ic_gnt", g), ic_gnt, !e_dc);
      tick();
    end
    ic_rd_req = 1'b0; dc_rd_req = 1'b0;
    tick();
    chk("post-starve busy", busy, 0);

    // Table of single transactions with minimum latency
    for (int i = 0; i < 6; i++) begin
      ic_rd_req = vec[i].ic; dc_rd_req = vec[i].dcr; dc_wr_req = vec[i].dcw;
      ic_addr = vec[i].ic_a; dc_addr = vec[i].dc_a; dc_wr_data = wline(i);
      tick();
      chk($sformatf("vec[%0d] mem_req", i), mem_req, 1);
      chk($sformatf("vec[%0d] mem_we", i), mem_we, vec[i].exp_we);
      chk($sformatf("vec[%0d] mem_addr", i), mem_addr, vec[i].exp_addr);
      if (vec[i].exp_we) chk($sformatf("vec[%0d] mem_wr_data", i), mem_wr_data, wline(i));
      mem_ready = 1'b1; mem_rd_data = rline(i);
      tick();
      mem_ready = 1'b0;
      chk($sformatf("vec[%0d] wait mem_req", i), mem_req, 0);
      chk($sformatf("vec[%0d] early gnt", i), {ic_gnt, dc_gnt}, 0);
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      chk($sformatf("vec[%0d] dc_gnt", i), dc_gnt, vec[i].exp_dc);
      chk($sformatf("vec[%0d] ic_gnt", i), ic_gnt, !vec[i].exp_dc);
      if (!vec[i].exp_we) begin
        if (vec[i].exp_dc) exp_dc_line = rline(i); else exp_ic_line = rline(i);
      end
      chk($sformatf("vec[%0d] ic_rd_data", i), ic_rd_data, exp_ic_line);
      chk($sformatf("vec[%0d] dc_rd_data", i), dc_rd_data, exp_dc_line);
      if (!vec[i].exp_dc) ic_rd_req = 1'b0;
      else if (vec[i].exp_we) dc_wr_req = 1'b0;
      else dc_rd_req = 1'b0;
      tick();
      chk($sformatf("vec[%0d] gnt pulse width", i), {ic_gnt, dc_gnt}, 0);
      chk($sformatf("vec[%0d] busy idle", i), busy, 0);
    end
    ic_rd_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
    tick();

    // mem_ready stalled for 10 cycles with a spurious mem_done while in ISSUE
    wd = wline(99);
    dc_wr_req = 1'b1; dc_addr = 32'h0000_0ABC; dc_wr_data = wd;
    tick();
    dc_wr_data = wline(98);
    for (int c = 0; c < 10; c++) begin
      mem_done = (c == 3);
      chk($sformatf("stall[%0d] mem_req", c), mem_req, 1);
      chk($sformatf("stall[%0d] mem_addr", c), mem_addr, 32'h0000_0AA0);
      chk($sformatf("stall[%0d] mem_wr_data", c), mem_wr_data, wd);
      chk($sformatf("stall[%0d] mem_we", c), mem_we, 1);
      chk($sformatf("stall[%0d] gnt", c), {ic_gnt, dc_gnt}, 0);
      tick();
    end
    mem_done = 1'b0;
    chk("stall spurious done ignored", mem_req, 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    chk("stall no gnt before done", {ic_gnt, dc_gnt, busy}, 3'b001);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("stall dc_gnt", dc_gnt, 1);
    chk("stall dc_rd_data kept", dc_rd_data, exp_dc_line);
    dc_wr_req = 1'b0;
    tick();

    // Asynchronous reset while in WAIT, then the pending icache read completes
    ic_rd_req = 1'b1; ic_addr = 32'h0000_1004;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("pre-reset busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async reset");
    exp_ic_line = '0; exp_dc_line = '0;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick();
    chk("reset no gnt", {ic_gnt, dc_gnt}, 0);
    rst = 1'b0;
    tick();
    chk("after reset mem_req", mem_req, 1);
    chk("after reset mem_addr", mem_addr, 32'h0000_1000);
    mem_ready = 1'b1; mem_rd_data = rline(77);
    tick();
    mem_ready = 1'b0; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("after reset ic_gnt", ic_gnt, 1);
    chk("after reset ic_rd_data", ic_rd_data, rline(77));
    ic_rd_req = 1'b0;
    tick();
    chk("after reset idle", {ic_gnt, dc_gnt, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
